// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Three-port, one-access-per-clkref-slot arbiter feeding the
//            single-port SDRAM controller, with a port 2 starvation guard.
// Revision : 1.0
// ============================================================================
module sdram_arbiter #(
    parameter int RD_PHASE   = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        clkref,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [7:0]  p0_din,
    input  logic        p0_aux,
    output logic        p0_ack,
    output logic [15:0] p0_dout,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [24:0] p1_addr,
    input  logic [7:0]  p1_din,
    input  logic        p1_aux,
    output logic        p1_ack,
    output logic [15:0] p1_dout,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [24:0] p2_addr,
    input  logic [7:0]  p2_din,
    input  logic        p2_aux,
    output logic        p2_ack,
    output logic [15:0] p2_dout,

    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_aux,
    input  logic [15:0] mem_dout,

    output logic [1:0]  gnt
);

    localparam logic [1:0] C_GNT_IDLE   = 2'd3;
    localparam logic [3:0] C_RD_PHASE   = 4'(RD_PHASE);
    localparam logic [2:0] C_STARVE_MAX = 3'(STARVE_MAX);

    logic [2:0]  w_req;
    logic [2:0]  w_we;
    logic [2:0]  w_aux;
    logic [24:0] w_addr [3];
    logic [7:0]  w_din  [3];
    logic        w_slot_start;
    logic [1:0]  w_win;

    logic        clkref_d_q;
    logic        busy_q,   busy_d;
    logic [3:0]  phase_q,  phase_d;
    logic [2:0]  starve_q, starve_d;
    logic [1:0]  gnt_q,    gnt_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q,  mem_din_d;
    logic        mem_we_q,   mem_we_d;
    logic        mem_aux_q,  mem_aux_d;
    logic [2:0]  ack_q,  ack_d;
    logic [15:0] dout_q [3];
    logic [15:0] dout_d [3];

    assign w_req     = {p2_req, p1_req, p0_req};
    assign w_we      = {p2_we,  p1_we,  p0_we};
    assign w_aux     = {p2_aux, p1_aux, p0_aux};
    assign w_addr[0] = p0_addr;
    assign w_addr[1] = p1_addr;
    assign w_addr[2] = p2_addr;
    assign w_din[0]  = p0_din;
    assign w_din[1]  = p1_din;
    assign w_din[2]  = p2_din;

    // An edge arriving while a slot is still in flight is dropped, not queued.
    assign w_slot_start = clkref & ~clkref_d_q & ~busy_q;

    always_comb begin
        w_win = C_GNT_IDLE;
        if (w_req[2] && (starve_q == C_STARVE_MAX)) begin
            w_win = 2'd2;
        end else if (w_req[0]) begin
            w_win = 2'd0;
        end else if (w_req[1]) begin
            w_win = 2'd1;
        end else if (w_req[2]) begin
            w_win = 2'd2;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        phase_d    = phase_q;
        starve_d   = starve_q;
        gnt_d      = gnt_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = mem_we_q;
        mem_aux_d  = mem_aux_q;
        ack_d      = 3'b000;
        dout_d     = dout_q;

        if (w_slot_start) begin
            busy_d  = 1'b1;
            phase_d = 4'd0;
            gnt_d   = w_win;
            // Idle slots keep address/data so the controller sees a harmless read.
            mem_we_d = 1'b0;
            for (int n = 0; n < 3; n++) begin
                if (w_win == 2'(n)) begin
                    mem_addr_d = w_addr[n];
                    mem_din_d  = w_din[n];
                    mem_we_d   = w_we[n];
                    mem_aux_d  = w_aux[n];
                end
            end
            if ((w_win == 2'd2) || !w_req[2]) begin
                starve_d = 3'd0;
            end else if (starve_q != C_STARVE_MAX) begin
                starve_d = starve_q + 3'd1;
            end
        end else if (busy_q) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == C_RD_PHASE) begin
                busy_d = 1'b0;
                for (int n = 0; n < 3; n++) begin
                    if (gnt_q == 2'(n)) begin
                        ack_d[n] = 1'b1;
                        if (!mem_we_q) begin
                            dout_d[n] = mem_dout;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            clkref_d_q <= 1'b0;
            busy_q     <= 1'b0;
            phase_q    <= 4'd0;
            starve_q   <= 3'd0;
            gnt_q      <= C_GNT_IDLE;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_aux_q  <= 1'b0;
            ack_q      <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                dout_q[n] <= '0;
            end
        end else begin
            clkref_d_q <= clkref;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            starve_q   <= starve_d;
            gnt_q      <= gnt_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            mem_aux_q  <= mem_aux_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p2_ack   = ack_q[2];
    assign p0_dout  = dout_q[0];
    assign p1_dout  = dout_q[1];
    assign p2_dout  = dout_q[2];
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign mem_aux  = mem_aux_q;
    assign gnt      = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter: vector table, corner-case
//            sequences and random slots against a slot-level reference model.
// Revision : 1.0
// ============================================================================
module tb_sdram_arbiter;

    localparam int RD_PHASE   = 9;
    localparam int STARVE_MAX = 4;
    localparam int ACK_J      = RD_PHASE + 1;

    logic        clk = 1'b0;
    logic        init_n;
    logic        clkref;
    logic [2:0]  s_req;
    logic [2:0]  s_we;
    logic [2:0]  s_aux;
    logic [24:0] s_addr [3];
    logic [7:0]  s_din  [3];
    logic [15:0] mem_dout;

    logic        p0_ack, p1_ack, p2_ack;
    logic [15:0] p0_dout, p1_dout, p2_dout;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_aux;
    logic [1:0]  gnt;

    logic        p0_req, p1_req, p2_req;
    logic [24:0] p0_addr, p1_addr, p2_addr;
    logic [7:0]  p0_din, p1_din, p2_din;
    assign {p2_req, p1_req, p0_req} = s_req;
    assign p0_addr = s_addr[0];
    assign p1_addr = s_addr[1];
    assign p2_addr = s_addr[2];
    assign p0_din  = s_din[0];
    assign p1_din  = s_din[1];
    assign p2_din  = s_din[2];

    always #5 clk = ~clk;

    sdram_arbiter #(.RD_PHASE(RD_PHASE), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .init_n(init_n), .clkref(clkref),
        .p0_req(p0_req), .p0_we(s_we[0]), .p0_addr(p0_addr), .p0_din(p0_din),
        .p0_aux(s_aux[0]), .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(s_we[1]), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_aux(s_aux[1]), .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(s_we[2]), .p2_addr(p2_addr), .p2_din(p2_din),
        .p2_aux(s_aux[2]), .p2_ack(p2_ack), .p2_dout(p2_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_aux(mem_aux), .mem_dout(mem_dout), .gnt(gnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, tracked per slot rather than per clock.
    int          m_starve;
    logic [15:0] m_dout [3];
    logic [24:0] m_addr;
    logic [7:0]  m_din;
    logic        m_we, m_aux;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_starve = 0;
        for (int n = 0; n < 3; n++) m_dout[n] = 16'h0;
        m_addr = 25'h0;
        m_din  = 8'h0;
        m_we   = 1'b0;
        m_aux  = 1'b0;
    endtask

    function automatic int predict(input logic [2:0] req);
        if (req[2] && m_starve == STARVE_MAX) return 2;
        if (req[0]) return 0;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return 3;
    endfunction

    function automatic logic [87:0] all_outs();
        return {p0_dout, p1_dout, p2_dout, p2_ack, p1_ack, p0_ack,
                mem_addr, mem_din, mem_we, mem_aux, gnt};
    endfunction

    // One complete slot: raise clkref, follow 16 cycles, then return.
    task automatic run_slot(input logic [2:0] req, input logic [2:0] late, input logic [2:0] drop,
                            input bit glitch, input int rst_j, input logic [15:0] rd);
        int         win;
        bit         aborted;
        logic [2:0] exp_ack;
        aborted = 1'b0;
        @(negedge clk);
        s_req  = req;
        clkref = 1'b1;
        win = predict(req);
        if (win == 2 || !req[2]) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (win != 3) begin
            m_addr = s_addr[win];
            m_din  = s_din[win];
            m_we   = s_we[win];
            m_aux  = s_aux[win];
        end else begin
            m_we = 1'b0;
        end
        for (int j = 0; j <= 15; j++) begin
            @(negedge clk);
            mem_dout = (j == RD_PHASE) ? rd : (~rd ^ 16'(j));
            exp_ack = (j == ACK_J && win != 3 && !aborted) ? (3'b001 << win) : 3'b000;
            check("ack", {p2_ack, p1_ack, p0_ack}, exp_ack);
            if (j == 0 || j == ACK_J)
                check("gnt", gnt, aborted ? 2'd3 : 2'(win));
            if (j == 0 || j == RD_PHASE)
                check("mem", {mem_addr, mem_din, mem_we, mem_aux}, {m_addr, m_din, m_we, m_aux});
            if (j == ACK_J && win != 3 && !aborted) begin
                if (!s_we[win]) m_dout[win] = rd;
                s_req[win] = 1'b0;
            end
            if (j == ACK_J + 1)
                check("dout", {p0_dout, p1_dout, p2_dout}, {m_dout[0], m_dout[1], m_dout[2]});
            if (j == 2) clkref = 1'b0;
            if (j == 3) s_req = s_req & ~drop;
            if (glitch && j == 4) clkref = 1'b1;
            if (j == 5) s_req = s_req | late;
            if (glitch && j == 6) clkref = 1'b0;
            if (j == rst_j) begin
                #2 init_n = 1'b0;
                #1 check("reset_mid", all_outs(), {86'd0, 2'd3});
                #1 init_n = 1'b1;
                aborted = 1'b1;
                model_reset();
            end
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [2:0]  aux;
        logic [24:0] a0, a1, a2;
        logic [7:0]  d0, d1, d2;
        logic [15:0] rd;
        logic [2:0]  drop;
        bit          glitch;
        logic [1:0]  gnt;
    } vec_t;

    localparam int NV = 15;
    vec_t tab [NV];

    initial begin
        tab[0]  = '{3'b000, 3'b000, 3'b000, 25'h0000AA, 25'h0000BB, 25'h0000CC, 8'h11, 8'h22, 8'h33, 16'h1111, 3'b000, 1'b0, 2'd3};
        tab[1]  = '{3'b001, 3'b000, 3'b000, 25'h001234, 25'h000000, 25'h000000, 8'h00, 8'h00, 8'h00, 16'hA55A, 3'b000, 1'b0, 2'd0};
        tab[2]  = '{3'b111, 3'b000, 3'b000, 25'h010000, 25'h020000, 25'h030000, 8'h01, 8'h02, 8'h03, 16'hBEEF, 3'b000, 1'b0, 2'd0};
        tab[3]  = '{3'b110, 3'b000, 3'b000, 25'h010000, 25'h020000, 25'h030000, 8'h01, 8'h02, 8'h03, 16'h0F0F, 3'b000, 1'b0, 2'd1};
        tab[4]  = '{3'b010, 3'b010, 3'b010, 25'h000000, 25'h0FFFFF, 25'h000000, 8'h00, 8'h5C, 8'h00, 16'hDEAD, 3'b000, 1'b0, 2'd1};
        tab[5]  = '{3'b111, 3'b000, 3'b101, 25'h100001, 25'h100002, 25'h100003, 8'hA0, 8'hA1, 8'hA2, 16'h2001, 3'b000, 1'b0, 2'd0};
        tab[6]  = '{3'b111, 3'b000, 3'b101, 25'h100011, 25'h100012, 25'h100013, 8'hB0, 8'hB1, 8'hB2, 16'h2002, 3'b000, 1'b0, 2'd0};
        tab[7]  = '{3'b111, 3'b000, 3'b101, 25'h100021, 25'h100022, 25'h100023, 8'hC0, 8'hC1, 8'hC2, 16'h2003, 3'b000, 1'b0, 2'd0};
        tab[8]  = '{3'b111, 3'b000, 3'b101, 25'h100031, 25'h100032, 25'h100033, 8'hD0, 8'hD1, 8'hD2, 16'h2004, 3'b000, 1'b0, 2'd0};
        tab[9]  = '{3'b111, 3'b000, 3'b101, 25'h100041, 25'h100042, 25'h100043, 8'hE0, 8'hE1, 8'hE2, 16'h2005, 3'b000, 1'b0, 2'd2};
        tab[10] = '{3'b111, 3'b000, 3'b000, 25'h100051, 25'h100052, 25'h100053, 8'hF0, 8'hF1, 8'hF2, 16'h2006, 3'b000, 1'b0, 2'd0};
        tab[11] = '{3'b001, 3'b000, 3'b001, 25'h1ABCDE, 25'h000000, 25'h000000, 8'h77, 8'h00, 8'h00, 16'h3C3C, 3'b001, 1'b0, 2'd0};
        tab[12] = '{3'b100, 3'b000, 3'b000, 25'h000000, 25'h000000, 25'h1FFFFFF, 8'h00, 8'h00, 8'h99, 16'h4242, 3'b000, 1'b1, 2'd2};
        tab[13] = '{3'b000, 3'b111, 3'b111, 25'h0AAAAA, 25'h0BBBBB, 25'h0CCCCC, 8'hAA, 8'hBB, 8'hCC, 16'h5555, 3'b000, 1'b0, 2'd3};
        tab[14] = '{3'b110, 3'b100, 3'b000, 25'h000100, 25'h000200, 25'h000300, 8'h10, 8'h20, 8'h30, 16'h6666, 3'b000, 1'b0, 2'd1};

        init_n   = 1'b0;
        clkref   = 1'b0;
        s_req    = 3'b000;
        s_we     = 3'b000;
        s_aux    = 3'b000;
        mem_dout = 16'h0;
        for (int n = 0; n < 3; n++) begin
            s_addr[n] = 25'h0;
            s_din[n]  = 8'h0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", all_outs(), {86'd0, 2'd3});
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            s_we  = tab[i].we;
            s_aux = tab[i].aux;
            s_addr[0] = tab[i].a0; s_addr[1] = tab[i].a1; s_addr[2] = tab[i].a2;
            s_din[0]  = tab[i].d0; s_din[1]  = tab[i].d1; s_din[2]  = tab[i].d2;
            run_slot(tab[i].req, 3'b000, tab[i].drop, tab[i].glitch, -1, tab[i].rd);
            check("tbl_gnt", gnt, tab[i].gnt);
        end

        // Reset pulsed at phase 5 of a port 2 read, then a normal slot.
        s_we = 3'b000;
        s_addr[2] = 25'h0123456;
        run_slot(3'b100, 3'b000, 3'b000, 1'b0, 5, 16'h7777);
        run_slot(3'b100, 3'b000, 3'b000, 1'b0, -1, 16'h8888);
        check("post_reset_gnt", gnt, 2'd2);

        // Request raised mid idle slot must wait for the next slot.
        run_slot(3'b000, 3'b010, 3'b000, 1'b0, -1, 16'h9999);
        check("late_idle_gnt", gnt, 2'd3);
        run_slot(3'b010, 3'b000, 3'b000, 1'b0, -1, 16'hAAAA);
        check("late_next_gnt", gnt, 2'd1);

        for (int i = 0; i < 40; i++) begin
            s_we  = 3'($urandom);
            s_aux = 3'($urandom);
            for (int n = 0; n < 3; n++) begin
                s_addr[n] = 25'($urandom);
                s_din[n]  = 8'($urandom);
            end
            run_slot(3'($urandom), 3'($urandom), 3'($urandom & $urandom),
                     ($urandom_range(0, 3) == 0), -1, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port slot arbiter placed in front of the single-port `sdram` controller. Each clkref period the controller performs exactly one access. At the start of each slot this block picks one requester, holds that requester's address, data and control on the controller inputs for the whole slot, and then returns the read word and an acknowledge. Port 0 carries CPU/video traffic, port 1 the ROM/ioctl download, and port 2 disk DMA. Port 2 has a starvation guard.

## Interface
Parameters:
- `RD_PHASE`, default 9: phase count after slot start at which `mem_dout` is valid and ack is issued. Legal range 3..13.
- `STARVE_MAX`, default 4: consecutive slots port 2 may be denied while requesting before it is forced to win.

Ports:
- `clk`  in  1  system clock; the same clock as the sdram controller.
- `init_n`  in  1  reset, asynchronous, active-low.
- `clkref`  in  1  slot reference; each rising edge, as sampled in `clk`, starts a slot.
- `pN_req`  in  1  access request for N = 0..2. Level signal, held until `pN_ack`.
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_addr`  in  25  byte address.
- `pN_din`  in  8  write byte.
- `pN_aux`  in  1  byte-lane select, passed through to the controller.
- `pN_ack`  out  1  one-`clk` pulse when the access completes.
- `pN_dout`  out  16  read word. Updated only on that port's read ack and held otherwise.
- `mem_addr`  out  25  to controller `addr`.
- `mem_din`  out  8  to controller `din`.
- `mem_we`  out  1  to controller `we`.
- `mem_aux`  out  1  to controller `aux`.
- `mem_dout`  in  16  from controller `dout`.
- `gnt`  out  2  port owning the current slot: 0..2, or 3 = idle.

## Operation
Slot detection:
- `clkref_d` is registered from `clkref`.
- `slot_start = clkref & ~clkref_d & ~busy`.

Arbitration happens at `slot_start`, with requests sampled only in that cycle:
- Starvation override: if `p2_req` is high and `starve == STARVE_MAX`, port 2 wins.
- Otherwise fixed priority applies: port 0, then port 1, then port 2.
- If no request is present, the slot is idle:
  - `gnt` = 3.
  - `mem_we` = 0.
  - `mem_addr`, `mem_din` and `mem_aux` hold their previous values, so the controller performs a harmless read.

Latching on a grant:
- The winner's `addr`, `din`, `we` and `aux` are registered onto `mem_*` in the `slot_start` cycle.
- They stay stable until the next `slot_start`.
- `busy` is set to 1 and `phase` is set to 0.

Phase counter:
- `phase` is 4 bits. It increments every clk while `busy`.
- At `phase == RD_PHASE` and `gnt != 3`:
  - `pN_ack` pulses for one clk.
  - For a read, `pN_dout` is loaded from `mem_dout`. For a write, `pN_dout` is unchanged.
  - `busy` is cleared.
- At `phase == RD_PHASE` and `gnt == 3`: `busy` is cleared with no ack.

Starvation counter `starve` (3 bits):
- Updated at each `slot_start`.
- Incremented, saturating at `STARVE_MAX`, when `p2_req` is high and port 2 is not granted.
- Cleared when port 2 is granted or `p2_req` is low.

Requester rule:
- `req` must drop by the cycle after ack, or a new access begins.
- A `req` still high at the next `slot_start` is treated as a new access.

## Timing
Reset (`init_n` low), applied asynchronously:
- All `pN_ack` = 0 and all `pN_dout` = 0.
- `mem_addr`, `mem_din`, `mem_we`, `mem_aux` = 0.
- `gnt` = 3, `busy` = 0, `phase` = 0, `starve` = 0, `clkref_d` = 0.
- Consequently, if `clkref` is already high at reset release, the first clk starts a slot.

Latency:
- `mem_*` is valid 1 clk after the clkref rising edge is first seen high, i.e. in the cycle after `slot_start`.
- Ack occurs `RD_PHASE + 1` clks after `slot_start`.

Boundary conditions:
- Rising edge while busy (clkref faster than the slot): the edge is ignored and no grant is made. The in-flight access completes normally.
- Simultaneous requests resolve in one cycle with no bubble.
- `init_n` asserted mid-slot: the access is aborted, no ack is issued, and all outputs return to reset values.
- Requests arriving between slot starts wait for the next slot.
- `pN_req` dropping mid-slot does not cancel the granted access; the ack is still issued.

## Test plan
- Single read: `p0_req=1`, `p0_addr=0x001234`, `mem_dout=0xA55A` at the ack cycle → `mem_addr=0x001234` and `mem_we=0` for the slot; `p0_ack` pulses at `slot_start+10` clks; `p0_dout=0xA55A`.
- All three request together → `gnt=0` and only `p0_ack` fires. With `p0` dropped, the next slot gives `gnt=1`.
- `p0` and `p1` held continuously with `p2_req=1` → `p2` is denied 4 slots, then `gnt=2` on slot 5 and `starve` returns to 0.
- Port 1 write: `din=0x5C`, `aux=1`, `addr=0x0FFFFF` → `mem_we=1`, `mem_din=0x5C`, `mem_aux=1`; `p1_ack` pulses; `p1_dout` is unchanged.
- No requests → `gnt=3`, `mem_we=0`, `mem_addr` held, no acks.
- `init_n` pulsed low at phase 5 of a port 2 read → no `p2_ack`; `gnt=3`; all outputs 0; the next clkref edge arbitrates normally.
